// File: rtl/imm_gen_if.sv
// D->X handshake bundle for imm_gen_pipe: decode-side entry plus X-side head entry.
// The master drives the entry and out_ready; the slave (the buffer) drives everything else.
interface imm_gen_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic [2:0]      in_imm_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output in_valid, in_pc, in_inst, in_imm_sel, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_imm_sel, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_imm, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Immediate generator on the D->X boundary: expands ImmSel at accept and holds entries in a 2-deep skid FIFO.
// Optional macro IMMGEN_ILLEGAL_CHECK_EN stores a per-entry reserved-ImmSel flag driven on out_illegal.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    imm_gen_if.slave bus
);
    logic [1:0]      count_reg, count_next;
    logic            rd_ptr_reg, rd_ptr_next;
    logic            wr_ptr_reg, wr_ptr_next;
    logic [XLEN-1:0] pc_mem_reg   [DEPTH];
    logic [XLEN-1:0] inst_mem_reg [DEPTH];
    logic [XLEN-1:0] imm_mem_reg  [DEPTH];
    logic            in_ready_int;
    logic            out_valid_int;
    logic            accept;
    logic            pop;
    logic [XLEN-1:0] new_imm;

    function automatic logic [31:0] expand_imm(input logic [31:0] i, input logic [2:0] sel);
        logic [31:0] imm;
        imm = '0;
        case (sel)
            3'd0: imm = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd1: imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd2: imm = {i[31:12], 12'b0};
            // inst[3] separates JAL (J-type) from JALR (I-type) under the shared jump code
            3'd3: imm = i[3] ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
                             : {{20{i[31]}}, i[31:20]};
            3'd4: imm = {{20{i[31]}}, i[31:20]};
            3'd5: imm = {27'b0, i[24:20]};
            3'd6: imm = {27'b0, i[19:15]};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    assign new_imm       = expand_imm(bus.in_inst, bus.in_imm_sel);
    assign in_ready_int  = (count_reg != 2'd2) & ~rst;
    assign out_valid_int = (count_reg != 2'd0) & ~rst;
    assign accept        = bus.in_valid & in_ready_int;
    assign pop           = out_valid_int & bus.out_ready;

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (flush) begin
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else begin
            if (accept) wr_ptr_next = ~wr_ptr_reg;
            if (pop)    rd_ptr_next = ~rd_ptr_reg;
            case ({accept, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // Flushed entries keep their payload; only the count/pointers forget them.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic IDX = 1'(gi);
            always_ff @(posedge clk) begin
                if (rst) begin
                    pc_mem_reg[gi]   <= '0;
                    inst_mem_reg[gi] <= '0;
                    imm_mem_reg[gi]  <= '0;
                end else if (accept && !flush && wr_ptr_reg == IDX) begin
                    pc_mem_reg[gi]   <= bus.in_pc;
                    inst_mem_reg[gi] <= bus.in_inst;
                    imm_mem_reg[gi]  <= new_imm;
                end
            end
        end
    endgenerate

`ifdef IMMGEN_ILLEGAL_CHECK_EN
    logic ill_mem_reg [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ill
            localparam logic IDX = 1'(gi);
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    ill_mem_reg[gi] <= 1'b0;
                end else if (accept && wr_ptr_reg == IDX) begin
                    ill_mem_reg[gi] <= (bus.in_imm_sel == 3'd7);
                end
            end
        end
    endgenerate

    assign bus.out_illegal = ill_mem_reg[rd_ptr_reg] & out_valid_int;
`else
    assign bus.out_illegal = 1'b0;
`endif

    // Data outputs are forced to zero during reset, before the storage clears on the edge.
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_pc    = rst ? '0 : pc_mem_reg[rd_ptr_reg];
    assign bus.out_inst  = rst ? '0 : inst_mem_reg[rd_ptr_reg];
    assign bus.out_imm   = rst ? '0 : imm_mem_reg[rd_ptr_reg];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: queue model checked every cycle plus directed literal checks.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    imm_gen_if #(.XLEN(32)) bus ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic        ill;
    } ent_t;

    ent_t q[$];

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        return 32'($signed(v << (32 - n)) >>> (32 - n));
    endfunction

    // Immediate built from the instruction fields by format, then widened by value.
    function automatic logic [31:0] model_imm(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            3'd0: return sext({20'b0, i[31:25], i[11:7]}, 12);
            3'd1: return sext({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            3'd2: return i & 32'hFFFF_F000;
            3'd3: return i[3] ? sext({11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21)
                              : sext(i >> 20, 12);
            3'd4: return sext(i >> 20, 12);
            3'd5: return (i >> 20) & 32'h1F;
            3'd6: return (i >> 15) & 32'h1F;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_ill(input logic [2:0] sel);
`ifdef IMMGEN_ILLEGAL_CHECK_EN
        return sel == 3'd7;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the active edge with the inputs as the DUT saw them.
    always @(posedge clk) begin
        int   sz;
        ent_t e;
        sz = q.size();
        if (rst || flush) begin
            q.delete();
        end else begin
            if (sz > 0 && bus.out_ready) begin
                e = q.pop_front();
                $display("pop  pc=%h inst=%h imm=%h", e.pc, e.inst, e.imm);
            end
            if (bus.in_valid && sz < 2) begin
                e.pc   = bus.in_pc;
                e.inst = bus.in_inst;
                e.imm  = model_imm(bus.in_inst, bus.in_imm_sel);
                e.ill  = model_ill(bus.in_imm_sel);
                q.push_back(e);
                $display("push pc=%h inst=%h sel=%0d imm=%h", e.pc, e.inst, bus.in_imm_sel, e.imm);
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready), 32'(!rst && q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(!rst && q.size() != 0));
        if (rst) begin
            chk("rst_out_pc", bus.out_pc, 32'h0);
            chk("rst_out_inst", bus.out_inst, 32'h0);
            chk("rst_out_imm", bus.out_imm, 32'h0);
            chk("rst_out_illegal", 32'(bus.out_illegal), 32'h0);
        end else if (q.size() != 0) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_inst", bus.out_inst, q[0].inst);
            chk("out_imm", bus.out_imm, q[0].imm);
            chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [2:0] sel);
        bus.in_valid   = 1'b1;
        bus.in_pc      = pc;
        bus.in_inst    = inst;
        bus.in_imm_sel = sel;
    endtask

    logic [31:0] vec_inst [8];
    logic [2:0]  vec_sel  [8];
    logic [31:0] vec_imm  [8];

    initial begin
        vec_inst = '{32'hFE112E23, 32'hFE000EE3, 32'h123450B7, 32'hFFF00093,
                     32'h0080006F, 32'h00008067, 32'h4030D093, 32'h51E2D073};
        vec_sel  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd3, 3'd5, 3'd6};
        vec_imm  = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFFF,
                     32'h00000008, 32'h00000000, 32'h00000003, 32'h00000005};

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.in_imm_sel = '0;
        bus.out_ready = 1'b0;
        tick(); tick();
        chk("reset_in_ready", 32'(bus.in_ready), 32'h0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_reset_in_ready", 32'(bus.in_ready), 32'h1);

        // Expansion, one entry per cycle with the X stage always ready.
        bus.out_ready = 1'b1;
        drive(32'h1000, vec_inst[0], vec_sel[0]);
        chk("no_bypass", 32'(bus.out_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("exp_valid", 32'(bus.out_valid), 32'h1);
            chk("exp_imm", bus.out_imm, vec_imm[i]);
            chk("exp_pc", bus.out_pc, 32'h1000 + 32'(4 * i));
            if (i < 7) drive(32'h1000 + 32'(4 * (i + 1)), vec_inst[i + 1], vec_sel[i + 1]);
            else bus.in_valid = 1'b0;
        end
        tick();
        chk("drain_valid", 32'(bus.out_valid), 32'h0);

        // Reserved ImmSel.
        drive(32'h2000, 32'hFFFFFFFF, 3'd7);
        tick();
        bus.in_valid = 1'b0;
        chk("sel7_imm", bus.out_imm, 32'h0);
`ifdef IMMGEN_ILLEGAL_CHECK_EN
        chk("sel7_illegal", 32'(bus.out_illegal), 32'h1);
`else
        chk("sel7_illegal", 32'(bus.out_illegal), 32'h0);
`endif
        tick();

        // Backpressure: third entry is held at the input until space frees up.
        bus.out_ready = 1'b0;
        drive(32'h100, 32'h123450B7, 3'd2); tick();
        drive(32'h104, 32'h123450B7, 3'd2); tick();
        drive(32'h108, 32'h123450B7, 3'd2); tick();
        chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
        chk("bp_head", bus.out_pc, 32'h100);
        tick();
        chk("bp_stable", bus.out_pc, 32'h100);
        chk("bp_in_ready2", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_second", bus.out_pc, 32'h104);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_third", bus.out_pc, 32'h108);
        tick();
        chk("bp_empty", 32'(bus.out_valid), 32'h0);

        // Flush with a full buffer and a pending entry.
        bus.out_ready = 1'b0;
        drive(32'h200, 32'hFFF00093, 3'd4); tick();
        drive(32'h204, 32'hFFF00093, 3'd4); tick();
        drive(32'h208, 32'hFFF00093, 3'd4); flush = 1'b1; tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'h1);
        drive(32'h20C, 32'hFFF00093, 3'd4); tick();
        bus.in_valid = 1'b0;
        chk("post_flush_valid", 32'(bus.out_valid), 32'h1);
        chk("post_flush_pc", bus.out_pc, 32'h20C);
        // Flush with room available still drops the incoming entry.
        drive(32'h300, 32'hFFF00093, 3'd4); flush = 1'b1; tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_drop_valid", 32'(bus.out_valid), 32'h0);
        tick();
        chk("flush_drop_valid2", 32'(bus.out_valid), 32'h0);

        // Reset mid-stream with one entry buffered.
        drive(32'h400, 32'hFFF00093, 3'd4); tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_imm", bus.out_imm, 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        chk("rst_valid2", 32'(bus.out_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("after_rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("after_rst_valid", 32'(bus.out_valid), 32'h0);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Consumer of the decode-stage 3-bit ImmSel code: expands the instruction's immediate field into a 32-bit operand for the execute stage.
- Sits on the D→X boundary as a 2-entry elastic (skid) buffer with valid/ready on both sides, so the decode logic and X stage decouple under stalls.
- Carries pc and inst alongside the generated immediate; supports a synchronous pipeline flush.

Parameters:
- XLEN, 32, datapath width of pc, inst and imm.
- DEPTH, 2, buffer entries; only 2 is supported.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  discard all buffered entries (branch mispredict or trap)
- in_valid  input  1  D-stage entry valid
- in_ready  output  1  buffer can accept an entry
- in_pc  input  XLEN  instruction PC
- in_inst  input  XLEN  raw instruction
- in_imm_sel  input  3  ImmSel code from decode
- out_valid  output  1  head entry valid
- out_ready  input  1  X stage accepts the head entry
- out_pc  output  XLEN  head PC
- out_inst  output  XLEN  head instruction
- out_imm  output  XLEN  head generated immediate
- out_illegal  output  1  head had a reserved ImmSel (optional feature)

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- ImmSel expansion, combinational on input, stored at accept. All sign extension is from inst[31].
  - 0 = S: {inst[31:25], inst[11:7]}, sign-extended.
  - 1 = B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, sign-extended.
  - 2 = U: {inst[31:12], 12'b0}.
  - 3 = jump: if inst[3]=1 (JAL), J-type {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} sign-extended; if inst[3]=0 (JALR), I-type.
  - 4 = I: inst[31:20], sign-extended.
  - 5 = shamt: {27'b0, inst[24:20]}.
  - 6 = CSR zimm: {27'b0, inst[19:15]}.
  - 7 = reserved: imm = 0.
- Storage: 2-entry FIFO with registered count (0..2), read pointer and write pointer (1 bit each, wrap 1→0).
- Handshake:
  - Accept when in_valid & in_ready; pop when out_valid & out_ready.
  - in_ready = (count != 2) & ~rst. It depends only on registered state; no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_* fields come from the head entry. They are meaningful only while out_valid=1.
- Latency: an accepted entry appears on out_* the next cycle. There is no same-cycle bypass when empty.
- Simultaneous accept and pop:
  - count = 1: count unchanged, both pointers advance.
  - count = 2: accept is impossible because in_ready = 0.
- Order: strictly FIFO. Payload is held stable while out_valid & ~out_ready.
- Flush: next cycle count = 0 and both pointers = 0. Flush has priority over a same-cycle accept or pop. The incoming entry is dropped, and an X-stage pop in the flush cycle is still considered consumed by X.
- Reset: count = 0, pointers = 0, all entry storage = 0. While rst is high: in_ready = 0, out_valid = 0, out_pc/out_inst/out_imm = 0, out_illegal = 0. Reset mid-stream discards all entries.
- No X-propagation: unused entries read as last-written or reset value.

Optional Feature:
- Macro: IMMGEN_ILLEGAL_CHECK_EN.
- Defined: each entry stores an illegal bit = (in_imm_sel == 3'd7). out_illegal reflects the head entry's bit. It is cleared by reset and flush.
- Undefined: no illegal bit is stored and out_illegal is tied to 0. The reserved code still yields imm = 0.

Test Plan:
- Expansion, out_ready=1, one per cycle:
  - 0xFE112E23 sel0 → 0xFFFFFFFC
  - 0xFE000EE3 sel1 → 0xFFFFFFFC
  - 0x123450B7 sel2 → 0x12345000
  - 0xFFF00093 sel4 → 0xFFFFFFFF
  - each arrives exactly 1 cycle after accept
- Jump and zero-extend:
  - 0x0080006F sel3 → 0x00000008
  - 0x00008067 sel3 → 0x00000000
  - 0x4030D093 sel5 → 0x00000003 (not 0x403)
  - 0x51E2D073 sel6 → 0x00000005
- Backpressure: out_ready=0, push pc 0x100, 0x104, 0x108 → in_ready drops after two accepts and 0x108 is held at input. Raise out_ready → outputs 0x100, 0x104, 0x108 in order, with out_* stable while stalled.
- Flush: count=2 and in_valid=1 with flush=1 → next cycle out_valid=0, in_ready=1, dropped entry never appears. The next push emerges 1 cycle later.
- Reset mid-stream: count=1, assert rst one cycle → out_valid=0, out_imm=0, in_ready=0 during reset, then 1 after.
- Option: with IMMGEN_ILLEGAL_CHECK_EN, sel7 → out_imm=0 and out_illegal=1. Without the macro, out_illegal=0.
